// File: rtl/usr_pkg.sv
// Shared types and helpers for the universal shift register.
package usr_pkg;

  // Operation select; all eight encodings are defined.
  typedef enum logic [2:0] {
    USR_HOLD = 3'b000,
    USR_SHL  = 3'b001,
    USR_SHR  = 3'b010,
    USR_ROL  = 3'b011,
    USR_ROR  = 3'b100,
    USR_LOAD = 3'b101,
    USR_ASR  = 3'b110,
    USR_CLR  = 3'b111
  } usr_mode_e;

  // True for operations that advance the frame counter.
  function automatic logic is_shift(input usr_mode_e m);
    case (m)
      USR_SHL, USR_SHR, USR_ROL, USR_ROR, USR_ASR: is_shift = 1'b1;
      default:                                     is_shift = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/usr_frame_cnt.sv
// Mod-WIDTH shift counter with a registered one-cycle wrap pulse.
module usr_frame_cnt #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_wrap
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_wrap;

  // Count shift operations; clear aborts the frame, wrap pulses once per frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (i_clr) begin
        r_cnt <= '0;
      end else if (i_inc) begin
        if (r_cnt == CNT_MAX) begin
          r_cnt  <= '0;
          r_wrap <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_cnt  = r_cnt;
  assign o_wrap = r_wrap;

endmodule

// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register with frame counter.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int             CNT_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic [WIDTH-1:0] pdin,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             frame_done
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_next;
  usr_mode_e        w_mode;
  logic             w_inc;
  logic             w_clr;

  assign w_mode = usr_mode_e'(mode);
  assign w_inc  = en & is_shift(w_mode);
  assign w_clr  = en & ((w_mode == USR_LOAD) | (w_mode == USR_CLR));

  // Mode mux: next register contents for the selected operation.
  always_comb begin
    w_q_next = r_q;
    case (w_mode)
      USR_HOLD: w_q_next = r_q;
      USR_SHL:  w_q_next = {r_q[WIDTH-2:0], sin_l};
      USR_SHR:  w_q_next = {sin_r, r_q[WIDTH-1:1]};
      USR_ROL:  w_q_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
      USR_ROR:  w_q_next = {r_q[0], r_q[WIDTH-1:1]};
      USR_LOAD: w_q_next = pdin;
      USR_ASR:  w_q_next = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
      USR_CLR:  w_q_next = '0;
      default:  w_q_next = r_q;
    endcase
  end

  // Data register: updates only when enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= RESET_VAL;
    end else if (en) begin
      r_q <= w_q_next;
    end
  end

  usr_frame_cnt #(
    .WIDTH (WIDTH)
  ) u_frame_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_inc  (w_inc),
    .i_clr  (w_clr),
    .o_cnt  (shift_cnt),
    .o_wrap (frame_done)
  );

  assign q      = r_q;
  assign sout_l = r_q[WIDTH-1];
  assign sout_r = r_q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Randomised and directed bench for univ_shift_reg at WIDTH 4, 2 and 16.
module tb_univ_shift_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [2:0]  mode = 3'b000;
  logic        sin_l = 1'b0;
  logic        sin_r = 1'b0;
  logic [15:0] pdin = '0;

  logic [3:0]  q4;  logic sl4, sr4, fd4; logic [1:0] c4;
  logic [1:0]  q2;  logic sl2, sr2, fd2; logic [0:0] c2;
  logic [15:0] q16; logic sl16, sr16, fd16; logic [3:0] c16;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(4), .RESET_VAL(4'b0000)) dut4 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_l(sin_l), .sin_r(sin_r),
    .pdin(pdin[3:0]), .q(q4), .sout_l(sl4), .sout_r(sr4), .shift_cnt(c4), .frame_done(fd4));

  univ_shift_reg #(.WIDTH(2), .RESET_VAL(2'b00)) dut2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_l(sin_l), .sin_r(sin_r),
    .pdin(pdin[1:0]), .q(q2), .sout_l(sl2), .sout_r(sr2), .shift_cnt(c2), .frame_done(fd2));

  univ_shift_reg #(.WIDTH(16), .RESET_VAL(16'hA5A5)) dut16 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_l(sin_l), .sin_r(sin_r),
    .pdin(pdin), .q(q16), .sout_l(sl16), .sout_r(sr16), .shift_cnt(c16), .frame_done(fd16));

  // Reference model state, one slot per instance.
  int unsigned w_of[3]   = '{4, 2, 16};
  int unsigned rv_of[3]  = '{0, 0, 32'hA5A5};
  int unsigned mq[3];
  int unsigned mcnt[3];
  int unsigned mdone[3];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned model_next(input int unsigned qq, input logic [2:0] m,
                                             input int unsigned w, input logic sl, input logic sr,
                                             input logic [15:0] pd);
    int unsigned mask = (32'd1 << w) - 1;
    int unsigned top  = 32'd1 << (w - 1);
    case (m)
      3'd1:    return ((qq << 1) | 32'(sl)) & mask;
      3'd2:    return (qq >> 1) | (32'(sr) << (w - 1));
      3'd3:    return ((qq << 1) | (qq >> (w - 1))) & mask;
      3'd4:    return (qq >> 1) | ((qq & 1) << (w - 1));
      3'd5:    return 32'(pd) & mask;
      3'd6:    return (qq >> 1) | (qq & top);
      3'd7:    return 0;
      default: return qq;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mq[i] = rv_of[i]; mcnt[i] = 0; mdone[i] = 0;
    end
  endtask

  task automatic model_clock(input logic e, input logic [2:0] m, input logic sl, input logic sr,
                             input logic [15:0] pd);
    for (int i = 0; i < 3; i++) begin
      mdone[i] = 0;
      if (e) begin
        mq[i] = model_next(mq[i], m, w_of[i], sl, sr, pd);
        if (m == 3'd5 || m == 3'd7) mcnt[i] = 0;
        else if (m != 3'd0) begin
          mcnt[i] = mcnt[i] + 1;
          if (mcnt[i] == w_of[i]) begin mcnt[i] = 0; mdone[i] = 1; end
        end
      end
    end
  endtask

  function automatic logic [31:0] obs(input int i, input int what);
    logic [31:0] v [3][5];
    v[0] = '{32'(q4),  32'(c4),  32'(fd4),  32'(sl4),  32'(sr4)};
    v[1] = '{32'(q2),  32'(c2),  32'(fd2),  32'(sl2),  32'(sr2)};
    v[2] = '{32'(q16), 32'(c16), 32'(fd16), 32'(sl16), 32'(sr16)};
    return v[i][what];
  endfunction

  task automatic check_all(input string tag);
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("%s.w%0d.q", tag, w_of[i]),    obs(i, 0), mq[i]);
      check_val($sformatf("%s.w%0d.cnt", tag, w_of[i]),  obs(i, 1), mcnt[i]);
      check_val($sformatf("%s.w%0d.done", tag, w_of[i]), obs(i, 2), mdone[i]);
      check_val($sformatf("%s.w%0d.soutl", tag, w_of[i]), obs(i, 3), (mq[i] >> (w_of[i] - 1)) & 1);
      check_val($sformatf("%s.w%0d.soutr", tag, w_of[i]), obs(i, 4), mq[i] & 1);
    end
  endtask

  task automatic step(input string tag, input logic e, input logic [2:0] m, input logic sl,
                      input logic sr, input logic [15:0] pd);
    @(negedge clk);
    en = e; mode = m; sin_l = sl; sin_r = sr; pdin = pd;
    @(posedge clk);
    model_clock(e, m, sl, sr, pd);
    #1;
    check_all(tag);
  endtask

  int pulses [3];
  logic [3:0] shl_bits;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("rst0");
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-stream with q=1011, shift_cnt=2
    step("pre", 1'b1, 3'd5, 1'b0, 1'b0, 16'h000E);
    step("pre", 1'b1, 3'd3, 1'b0, 1'b0, 16'h0000);
    step("pre", 1'b1, 3'd3, 1'b0, 1'b0, 16'h0000);
    check_val("t1.q_pre", 32'(q4), 32'hB);
    check_val("t1.cnt_pre", 32'(c4), 32'd2);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("t1.async");
    en = 1'b1; mode = 3'd1; sin_l = 1'b1;
    @(posedge clk);
    #1;
    check_all("t1.hold");
    check_val("t1.q16", 32'(q16), 32'hA5A5);
    @(negedge clk);
    rst = 1'b0;
    step("clr", 1'b1, 3'd7, 1'b0, 1'b0, 16'h0);

    // SHL frame 1,1,0,1
    shl_bits = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      step("t2", 1'b1, 3'd1, shl_bits[k], 1'b0, 16'h0);
      case (k)
        0: check_val("t2.q1", 32'(q4), 32'b0001);
        1: check_val("t2.q2", 32'(q4), 32'b0011);
        2: check_val("t2.q3", 32'(q4), 32'b0110);
        default: check_val("t2.q4", 32'(q4), 32'b1101);
      endcase
    end
    check_val("t2.done", 32'(fd4), 32'd1);
    check_val("t2.cnt", 32'(c4), 32'd0);
    step("t2h", 1'b1, 3'd0, 1'b0, 1'b0, 16'h0);
    check_val("t2.done_off", 32'(fd4), 32'd0);

    // LOAD 1001, ROR x2, ROL
    step("t3", 1'b1, 3'd5, 1'b0, 1'b0, 16'h0009);
    step("t3", 1'b1, 3'd4, 1'b0, 1'b0, 16'h0);
    check_val("t3.ror1", 32'(q4), 32'b1100);
    step("t3", 1'b1, 3'd4, 1'b0, 1'b0, 16'h0);
    check_val("t3.ror2", 32'(q4), 32'b0110);
    step("t3", 1'b1, 3'd3, 1'b0, 1'b0, 16'h0);
    check_val("t3.rol", 32'(q4), 32'b1100);
    check_val("t3.soutr", 32'(sr4), 32'd0);
    check_val("t3.soutl", 32'(sl4), 32'd1);

    // LOAD 1000, ASR x3, SHR sin_r=0
    step("t4", 1'b1, 3'd5, 1'b0, 1'b0, 16'h0008);
    step("t4", 1'b1, 3'd6, 1'b0, 1'b0, 16'h0);
    check_val("t4.asr1", 32'(q4), 32'b1100);
    step("t4", 1'b1, 3'd6, 1'b0, 1'b0, 16'h0);
    check_val("t4.asr2", 32'(q4), 32'b1110);
    step("t4", 1'b1, 3'd6, 1'b0, 1'b0, 16'h0);
    check_val("t4.asr3", 32'(q4), 32'b1111);
    step("t4", 1'b1, 3'd2, 1'b0, 1'b0, 16'h0);
    check_val("t4.shr", 32'(q4), 32'b0111);
    check_val("t4.done", 32'(fd4), 32'd1);

    // en=0 blocks LOAD; LOAD mid-frame aborts
    step("t5", 1'b1, 3'd1, 1'b1, 1'b0, 16'h0);
    step("t5", 1'b0, 3'd5, 1'b0, 1'b0, 16'hFFFF);
    check_val("t5.q_hold", 32'(q4), 32'b1111);
    check_val("t5.cnt_hold", 32'(c4), 32'd1);
    step("t5", 1'b1, 3'd1, 1'b0, 1'b0, 16'h0);
    check_val("t5.cnt2", 32'(c4), 32'd2);
    step("t5", 1'b1, 3'd5, 1'b0, 1'b0, 16'h0003);
    check_val("t5.cnt_ld", 32'(c4), 32'd0);
    check_val("t5.done_ld", 32'(fd4), 32'd0);
    step("t5", 1'b1, 3'd1, 1'b0, 1'b0, 16'h0);
    step("t5", 1'b1, 3'd1, 1'b0, 1'b0, 16'h0);
    check_val("t5.no_pulse", 32'(fd4), 32'd0);

    // Frame cadence across widths: 48 shifts after a load
    step("t6", 1'b1, 3'd5, 1'b0, 1'b0, 16'h1234);
    pulses = '{0, 0, 0};
    for (int k = 0; k < 48; k++) begin
      step("t6", 1'b1, 3'd3, 1'b0, 1'b0, 16'h0);
      pulses[0] += int'(fd4); pulses[1] += int'(fd2); pulses[2] += int'(fd16);
    end
    check_val("t6.pulses_w4", 32'(pulses[0]), 32'd12);
    check_val("t6.pulses_w2", 32'(pulses[1]), 32'd24);
    check_val("t6.pulses_w16", 32'(pulses[2]), 32'd3);

    // Random traffic against the model
    for (int k = 0; k < 600; k++) begin
      step("rnd", ($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)),
           1'($urandom), 1'($urandom), 16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
